// File: rtl/qrs_detect_if.sv
// qrs_detect_if: sample stream in, beat/artifact events out for the QRS detector.
interface qrs_detect_if #(parameter int DATA_W = 12) ();
  logic [DATA_W-1:0] sample;
  logic              sample_valid;
  logic [DATA_W-1:0] threshold;
  logic              hb_detect;
  logic [DATA_W-1:0] peak_amp;
  logic              artifact;
  modport master (output sample, sample_valid, threshold, input hb_detect, peak_amp, artifact);
  modport slave  (input sample, sample_valid, threshold, output hb_detect, peak_amp, artifact);
endinterface

// File: rtl/qrs_detect.sv
// qrs_detect: rising-slope QRS detector with width qualification and refractory hold.
// Optional ADAPT_THRESH_EN raises the threshold to half a running average of beat peaks.
module qrs_detect #(
    parameter int DATA_W          = 12,
    parameter int MIN_WIDTH       = 2,
    parameter int MAX_WIDTH       = 20,
    parameter int REFRACT_SAMPLES = 50
) (
    input logic         clock,
    input logic         reset,
    qrs_detect_if.slave bus
);
    localparam int W_W = $clog2(MAX_WIDTH + 1);
    localparam int R_W = $clog2(REFRACT_SAMPLES + 1);
    typedef enum logic [1:0] {PRIME, SEARCH, PEAK, REFRACT} state_t;
    state_t              state;
    logic [DATA_W-1:0]   x1, x2, slope_q, pk, thr;
    logic                slope_vld, prime_cnt, hit;
    logic [W_W-1:0]      width;
    logic [R_W-1:0]      rcnt;
    logic signed [DATA_W:0] diff;
    assign diff = $signed({1'b0, bus.sample}) - $signed({1'b0, x2});
    assign hit  = slope_q >= thr;
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            x1        <= '0;
            x2        <= '0;
            slope_q   <= '0;
            slope_vld <= 1'b0;
        end else begin
            slope_vld <= bus.sample_valid;
            if (bus.sample_valid) begin
                x1      <= bus.sample;
                x2      <= x1;
                slope_q <= diff[DATA_W] ? '0 : diff[DATA_W-1:0];
            end
        end
    end
`ifdef ADAPT_THRESH_EN
    logic [DATA_W-1:0] avg;
    assign thr = (bus.threshold > (avg >> 1)) ? bus.threshold : (avg >> 1);
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            avg <= '0;
        else if (slope_vld && state == PEAK && !hit && width >= W_W'(MIN_WIDTH))
            avg <= avg - (avg >> 3) + (pk >> 3);
    end
`else
    assign thr = bus.threshold;
`endif
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= PRIME;
            prime_cnt     <= 1'b0;
            width         <= '0;
            rcnt          <= '0;
            pk            <= '0;
            bus.hb_detect <= 1'b0;
            bus.artifact  <= 1'b0;
            bus.peak_amp  <= '0;
        end else begin
            bus.hb_detect <= 1'b0;
            bus.artifact  <= 1'b0;
            if (slope_vld) begin
                case (state)
                    PRIME: begin
                        prime_cnt <= 1'b1;
                        if (prime_cnt) state <= SEARCH;
                    end
                    SEARCH: if (hit) begin
                        state <= PEAK;
                        width <= W_W'(1);
                        pk    <= slope_q;
                    end
                    PEAK: if (hit) begin
                        pk <= (slope_q > pk) ? slope_q : pk;
                        // Width saturates at MAX_WIDTH-1; the step that would reach MAX_WIDTH rejects instead.
                        if (width == W_W'(MAX_WIDTH - 1)) begin
                            bus.artifact <= 1'b1;
                            state        <= REFRACT;
                            rcnt         <= '0;
                        end else
                            width <= width + W_W'(1);
                    end else if (width >= W_W'(MIN_WIDTH)) begin
                        bus.hb_detect <= 1'b1;
                        bus.peak_amp  <= pk;
                        state         <= REFRACT;
                        rcnt          <= '0;
                    end else
                        state <= SEARCH;
                    REFRACT: begin
                        if (rcnt == R_W'(REFRACT_SAMPLES - 1)) state <= SEARCH;
                        else rcnt <= rcnt + R_W'(1);
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_qrs_detect.sv
// tb_qrs_detect: directed scenarios with an output scoreboard keyed to the two-cycle detector latency.
module tb_qrs_detect;
    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;
    qrs_detect_if #(.DATA_W(12)) bus ();
    qrs_detect #(.DATA_W(12), .MIN_WIDTH(2), .MAX_WIDTH(20), .REFRACT_SAMPLES(50)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );
    typedef struct {
        int          due;
        logic        hb;
        logic        art;
        logic [11:0] pk;
        string       tag;
    } exp_t;
    exp_t        sb[$];
    int          cyc    = 0;
    int          tests  = 0;
    int          fails  = 0;
    logic [11:0] exp_pk = '0;
    task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask
    // Called just after a falling edge; expectation for a valid sample is due two rising edges later.
    task automatic step(input logic v, input logic [11:0] s, input logic e_hb, input logic e_art, input string tag);
        exp_t e;
        bus.sample_valid = v;
        bus.sample       = s;
        if (v) begin
            e.due = cyc + 2; e.hb = e_hb; e.art = e_art; e.pk = exp_pk; e.tag = tag;
            sb.push_back(e);
        end
        @(posedge clock);
        cyc++;
        @(negedge clock);
        while (sb.size() > 0 && sb[0].due == cyc) begin
            exp_t c;
            c = sb.pop_front();
            check($sformatf("%s.hb@%0d", c.tag, cyc), {11'b0, bus.hb_detect}, {11'b0, c.hb});
            check($sformatf("%s.art@%0d", c.tag, cyc), {11'b0, bus.artifact}, {11'b0, c.art});
            check($sformatf("%s.pk@%0d", c.tag, cyc), bus.peak_amp, c.pk);
        end
    endtask
    task automatic run(input int n, input logic [11:0] s, input string tag);
        for (int i = 0; i < n; i++) step(1'b1, s, 1'b0, 1'b0, tag);
    endtask
    task automatic flush();
        repeat (2) step(1'b0, 12'd0, 1'b0, 1'b0, "idle");
        check("sb_empty", 12'(sb.size()), 12'd0);
    endtask
    task automatic pulse_reset();
        reset = 1'b0;
        @(posedge clock);
        cyc++;
        @(negedge clock);
        reset  = 1'b1;
        exp_pk = '0;
    endtask
    initial begin
        bus.sample       = '0;
        bus.sample_valid = 1'b0;
        bus.threshold    = 12'd100;
        @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            bus.sample       = 12'($urandom);
            bus.sample_valid = 1'($urandom);
            @(posedge clock);
            cyc++;
            @(negedge clock);
            check("rst.hb", {11'b0, bus.hb_detect}, 12'd0);
            check("rst.art", {11'b0, bus.artifact}, 12'd0);
            check("rst.pk", bus.peak_amp, 12'd0);
        end
        reset = 1'b1;
        run(2, 12'd4000, "prime");
        step(1, 12'd0, 0, 0, "beat"); step(1, 12'd0, 0, 0, "beat"); step(1, 12'd0, 0, 0, "beat");
        step(1, 12'd200, 0, 0, "beat"); step(1, 12'd400, 0, 0, "beat"); step(1, 12'd600, 0, 0, "beat");
        step(1, 12'd600, 0, 0, "beat");
        exp_pk = 12'd400;
        step(1, 12'd600, 1, 0, "beat_hb");
        // 50 ignored samples: an early edge, then a large slope on the very last ignored one
        step(1, 12'd600, 0, 0, "refr"); step(1, 12'd800, 0, 0, "refr");
        step(1, 12'd1000, 0, 0, "refr"); step(1, 12'd1200, 0, 0, "refr");
        run(45, 12'd600, "refr");
        step(1, 12'd2000, 0, 0, "refr_last");
        step(1, 12'd900, 0, 0, "refr_first");
        step(1, 12'd2100, 0, 0, "beat2");
        exp_pk = 12'd300;
        step(1, 12'd900, 1, 0, "beat2_hb");
        run(3, 12'd900, "beat2_tail");
        flush();
        pulse_reset();
        run(2, 12'd0, "prime");
        step(1, 12'd0, 0, 0, "glitch"); step(1, 12'd150, 0, 0, "glitch");
        run(3, 12'd0, "glitch");
        step(1, 12'd200, 0, 0, "beat3"); step(1, 12'd400, 0, 0, "beat3");
        step(1, 12'd600, 0, 0, "beat3"); step(1, 12'd600, 0, 0, "beat3");
        exp_pk = 12'd400;
        step(1, 12'd600, 1, 0, "beat3_hb");
        run(50, 12'd600, "refr3");
        step(1, 12'd800, 0, 0, "peak"); step(1, 12'd1000, 0, 0, "peak");
        flush();
        #2 reset = 1'b0;
        #1;
        check("areset.hb", {11'b0, bus.hb_detect}, 12'd0);
        check("areset.art", {11'b0, bus.artifact}, 12'd0);
        check("areset.pk", bus.peak_amp, 12'd0);
        @(posedge clock);
        cyc++;
        @(negedge clock);
        reset  = 1'b1;
        exp_pk = '0;
        run(2, 12'd1000, "prime");
        step(1, 12'd1000, 0, 0, "fall"); step(1, 12'd500, 0, 0, "fall");
        run(3, 12'd0, "fall");
        step(1, 12'd200, 0, 0, "beat4"); step(1, 12'd400, 0, 0, "beat4");
        step(1, 12'd600, 0, 0, "beat4"); step(1, 12'd600, 0, 0, "beat4");
        exp_pk = 12'd400;
        step(1, 12'd600, 1, 0, "beat4_hb");
        flush();
        pulse_reset();
        bus.threshold = 12'd0;
        run(2, 12'd500, "prime");
        for (int i = 1; i <= 25; i++) step(1, 12'd500, 0, i == 20, "artifact");
        flush();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/qrs_detect.md
Name: qrs_detect

Overview:
Upstream stage of the heart-rate counter. Consumes the ECG sample stream and computes a rising-edge slope. Emits exactly one single-clock hb_detect pulse per qualified QRS complex, which the downstream heart-rate counter integrates over its sliding window. Enforces minimum peak width, maximum peak width (artifact reject) and a refractory period.

Parameters:
DATA_W, 12, sample width in bits (unsigned ADC code)
MIN_WIDTH, 2, minimum consecutive above-threshold slopes for a valid beat
MAX_WIDTH, 20, above-threshold slope count at which the peak is rejected as an artifact
REFRACT_SAMPLES, 50, samples ignored after a beat or artifact (200 ms at 250 Hz)

Ports:
clock  in  1  system clock; all state on posedge
reset  in  1  asynchronous, active-low reset (asserted when 0)
sample  in  DATA_W  ECG sample; valid only when sample_valid=1
sample_valid  in  1  sample strobe; may be high every cycle
threshold  in  DATA_W  slope threshold; sampled at every comparison
hb_detect  out  1  one-cycle pulse per accepted beat
peak_amp  out  DATA_W  maximum slope of the last accepted beat; held until the next beat
artifact  out  1  one-cycle pulse when a peak reaches MAX_WIDTH

Behaviour:
- Reset (reset=0, async): hb_detect=0, artifact=0, peak_amp=0, history=0, slope pipeline cleared, FSM=PRIME. Effective immediately, including mid-PEAK or mid-REFRACT; no pulse is emitted for an interrupted peak.
- History: x1 and x2 hold the previous two samples; both update only on sample_valid.
- Slope: on sample_valid, slope = sample - x2 as a signed DATA_W+1 value; negative results clamp to 0 (rising edges only). The result is registered into slope_q with slope_vld=1 for one cycle, so there is 1 cycle of latency.
- FSM acts only on cycles with slope_vld=1; otherwise it holds state.
- PRIME: count valid samples and ignore slopes. After 2 samples go to SEARCH, so the 3rd sample is the first compared.
- SEARCH: if slope_q>=thr, go to PEAK with width=1 and pk=slope_q.
- PEAK:
  - if slope_q>=thr: pk=max(pk,slope_q) and width+1. If width reaches MAX_WIDTH, pulse artifact and go to REFRACT; no hb_detect.
  - if slope_q<thr and width>=MIN_WIDTH: pulse hb_detect, load peak_amp<=pk, go to REFRACT.
  - if slope_q<thr and width<MIN_WIDTH: glitch; go to SEARCH silently.
- REFRACT: count slope_vld cycles. After REFRACT_SAMPLES of them, go to SEARCH; slopes are ignored throughout. The counter is cleared on entry.
- Latency: if the first sub-threshold sample arrives on cycle N, hb_detect is high on cycle N+2 only.
- hb_detect and artifact are registered, exactly one cycle wide, and never asserted together.
- A threshold change takes effect at the next comparison, including mid-PEAK.
- threshold=0: every slope passes, so any peak runs to MAX_WIDTH and yields an artifact.
- width counter sized for MAX_WIDTH; the refractory counter is sized for REFRACT_SAMPLES. Neither wraps.

Optional Feature:
ADAPT_THRESH_EN
- Defined: adds a register avg (DATA_W, reset 0). On each accepted beat, avg <= avg - (avg>>3) + (pk>>3). The effective threshold is max(threshold, avg>>1). Artifacts do not update avg.
- Undefined: the effective threshold is the threshold port; no avg register exists.
- Tests below assume the macro is undefined unless stated.

Test Plan:
- Reset: hold reset=0 with random sample activity -> hb_detect=0, artifact=0, peak_amp=0. Release, send 2 samples of 4000 -> no pulse (PRIME).
- Beat: threshold=100, samples 0,0,0,200,400,600,600,600 every cycle -> slopes 0,200,400,400,200,0. hb_detect is one cycle, 2 cycles after the 8th sample; peak_amp=400.
- Glitch/negative slope: threshold=100, samples 0,0,0,150,0,0,0 -> width 1 and the negative slope clamps to 0. No hb_detect, no artifact, FSM in SEARCH.
- Refractory: after the beat scenario, repeat the rising edge within 49 samples -> ignored. Repeat it after 50 more samples -> second hb_detect with peak_amp updated.
- Artifact: threshold=0, 25 constant samples after priming -> artifact pulse on the 20th compared slope, hb_detect stays 0, then REFRACT.
- Async reset mid-PEAK: assert reset=0 between clock edges after slope 400 -> outputs clear immediately. After release, no hb_detect until a fresh complete beat.
